conv_enc_r13: RTL and testbench
===============================

# conv_enc_r13

Rate-1/3, constraint-length-7 convolutional encoder on the transmit side of the OFDM chain. It accepts one information bit per handshake and emits one 3-bit codeword per bit, in the same codeword bit order the receive-side branch-metric/Viterbi path consumes (g0 on bit 2). Optionally, it appends K-1 zero tail bits per frame so the decoder trellis terminates in state 0.

## Interface
Parameters:
- G0, 7'o133, generator polynomial for do[2]; bit 6 taps the current input, bit 0 taps the oldest stored bit.
- G1, 7'o171, generator polynomial for do[1].
- G2, 7'o165, generator polynomial for do[0].

Ports:
- clk  in  1  working clock.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- di  in  1  information bit.
- di_vld  in  1  di valid.
- di_last  in  1  marks the last information bit of a frame; qualified by di_vld.
- di_rdy  out  1  encoder can accept di this cycle.
- do  out  3  codeword; do[2]=g0, do[1]=g1, do[0]=g2.
- do_vld  out  1  do valid.
- do_last  out  1  last codeword of a frame.
- do_rdy  in  1  downstream accepts do this cycle.

## Operation
- Shift register sr[1:6]: sr[1] is the previous accepted bit, sr[6] is the oldest. Reset value is all zero.
- Codeword for input u: v = {u, sr[1], …, sr[6]} (u is MSB). do[2]=^(v&G0), do[1]=^(v&G1), do[0]=^(v&G2).
- Accept: di_vld && di_rdy. On accept, the register load sets do and do_vld=1, and the shift is {u, sr[1:5]}.
- Output register is free when !do_vld || do_rdy.
- FSM states:
  - IDLE: waits for the first accept, then goes to DATA. An accept in IDLE with di_last=1 goes straight to TAIL.
  - DATA: stays in DATA until an accept with di_last=1, then goes to TAIL.
  - TAIL: issues 6 tail codewords with u=0, one per free output-register cycle. A 3-bit tail counter counts 0..5. After the 6th tail codeword, go to IDLE.
- di_rdy = (state≠TAIL) && output register free.
- do_last = 1 only on the final codeword of the frame (the 6th tail codeword in TAIL mode).
- After the final tail codeword, sr is all zero by construction. No explicit clear is needed.
- Frame length is unbounded; no internal bit counter.
- di_vld with di_rdy=0 has no effect; upstream holds di/di_last.

## Timing
- Reset values: do=0, do_vld=0, do_last=0, di_rdy=0 while rst is asserted and 1 in the first cycle after release. sr=0, state=IDLE, tail counter=0.
- Latency: codeword registered 1 cycle after accept.
- Throughput: 1 codeword/cycle with do_rdy held high. Per frame of N bits: N+6 output cycles with tail, N without.
- Backpressure: do, do_vld, and do_last hold stable while do_vld && !do_rdy. sr and the tail counter do not advance.
- The first data bit of the next frame is accepted in the cycle after the final tail codeword is loaded (state back in IDLE), subject to register free.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is discarded and no do_last is produced.

## Configuration
- CONV_ENC_TAIL_EN defined: TAIL state and 6 zero-tail codewords are included, as described above.
- CONV_ENC_TAIL_EN undefined:
  - TAIL state and tail counter are removed.
  - do_last is asserted with the codeword of the di_last bit.
  - sr is cleared to 0 on that accept, so the next frame starts from state 0.
  - The FSM reduces to IDLE/DATA.

## Test plan
- Impulse, TAIL_EN, do_rdy=1: single bit di=1 with di_last=1. Required output is 7 codewords 111, 011, 111, 110, 001, 100, 111, with do_last on the 7th only, and di_rdy=0 during the 6 tail cycles.
- All-zero frame, 16 bits, TAIL_EN: 22 codewords, all 000, do_last on the 22nd.
- Backpressure: same impulse frame with do_rdy toggled 1,0,0,1,… Sequence unchanged; do held stable on every stalled cycle; no lost or duplicated codeword.
- Back-to-back frames: two impulse frames presented continuously. Output is 111,011,111,110,001,100,111 twice; the second frame's first codeword appears the cycle after the first frame's last.
- Reset mid-frame: rst after 3 bits of a frame. Outputs go to 0 asynchronously. A following impulse frame reproduces the exact impulse sequence (sr was cleared).
- TAIL_EN undefined: bits 1,0 with di_last on the second bit. Output is 111, 011 with do_last on 011. A following single-bit-1 frame outputs 111 (state cleared).

Source files
------------

// File: rtl/conv_enc_r13.sv
// Rate-1/3, K=7 convolutional encoder with valid/ready handshakes on both sides.
// Define CONV_ENC_TAIL_EN to append six zero tail codewords per frame (trellis ends in state 0).
module conv_enc_r13 #(
    parameter logic [6:0] G0 = 7'o133,
    parameter logic [6:0] G1 = 7'o171,
    parameter logic [6:0] G2 = 7'o165
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       di,
    input  logic       di_vld,
    input  logic       di_last,
    output logic       di_rdy,
    output logic [2:0] do_data,
    output logic       do_vld,
    output logic       do_last,
    input  logic       do_rdy
);

    // state  | meaning
    // S_IDLE | between frames, waiting for the first bit
    // S_DATA | inside a frame, accepting information bits
    // S_TAIL | flushing six zero bits (tail build only)
`ifdef CONV_ENC_TAIL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_TAIL = 2'd2} state_t;
`else
    typedef enum logic {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;
`endif

    state_t     state, state_nxt;
    logic [5:0] sr;            // sr[5] is the previous accepted bit, sr[0] the oldest
    logic [6:0] v;
    logic       out_free;
    logic       accept;
    logic       load;
    logic       u;
    logic       last_cw;
`ifdef CONV_ENC_TAIL_EN
    logic [2:0] tail_cnt, tail_cnt_nxt;
    logic       tail_step;
`endif

    always_comb begin
        state_nxt = state;
        u         = di;
        last_cw   = 1'b0;
        out_free  = !do_vld || do_rdy;
        di_rdy    = !rst && out_free;
`ifdef CONV_ENC_TAIL_EN
        tail_step    = 1'b0;
        tail_cnt_nxt = tail_cnt;
        if (state == S_TAIL) di_rdy = 1'b0;
`endif
        accept = di_vld && di_rdy;

        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef CONV_ENC_TAIL_EN
                    state_nxt = di_last ? S_TAIL : S_DATA;
`else
                    state_nxt = di_last ? S_IDLE : S_DATA;
`endif
                end
            end
            S_DATA: begin
                if (accept && di_last) begin
`ifdef CONV_ENC_TAIL_EN
                    state_nxt = S_TAIL;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef CONV_ENC_TAIL_EN
            S_TAIL: begin
                if (out_free) begin
                    tail_step    = 1'b1;
                    u            = 1'b0;
                    tail_cnt_nxt = tail_cnt + 3'd1;
                    if (tail_cnt == 3'd5) begin
                        last_cw      = 1'b1;
                        tail_cnt_nxt = 3'd0;
                        state_nxt    = S_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

`ifdef CONV_ENC_TAIL_EN
        load = accept || tail_step;
`else
        last_cw = accept && di_last;
        load    = accept;
`endif
        v = {u, sr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sr      <= 6'd0;
            do_data <= 3'd0;
            do_vld  <= 1'b0;
            do_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                do_data <= {^(v & G0), ^(v & G1), ^(v & G2)};
                do_vld  <= 1'b1;
                do_last <= last_cw;
                sr      <= {u, sr[5:1]};
`ifndef CONV_ENC_TAIL_EN
                // Without a tail the next frame must still start from state 0.
                if (last_cw) sr <= 6'd0;
`endif
            end else if (do_rdy) begin
                do_vld  <= 1'b0;
                do_last <= 1'b0;
            end
        end
    end

`ifdef CONV_ENC_TAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tail_cnt <= 3'd0;
        else     tail_cnt <= tail_cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_conv_enc_r13.sv
// Bench for conv_enc_r13: directed frames plus randomized traffic against a convolution reference model.
module tb_conv_enc_r13;

`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL = 6;
`else
    localparam int TAIL = 0;
`endif
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o165;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       di = 1'b0, di_vld = 1'b0, di_last = 1'b0, do_rdy = 1'b0;
    logic       di_rdy, do_vld, do_last;
    logic [2:0] do_data;

    int tests = 0;
    int fails = 0;

    logic       fb[$];
    logic       in_bit[$];
    logic       in_last[$];
    logic [2:0] exp_cw[$];
    logic       exp_last[$];

    always #5 clk = ~clk;

    conv_enc_r13 dut (
        .clk(clk), .rst(rst),
        .di(di), .di_vld(di_vld), .di_last(di_last), .di_rdy(di_rdy),
        .do_data(do_data), .do_vld(do_vld), .do_last(do_last), .do_rdy(do_rdy)
    );

    task automatic check1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Codeword k is the convolution of the zero-started bit stream (frame + zero tail) with each generator.
    task automatic push_frame();
        int n   = fb.size();
        int tot = n + TAIL;
        for (int k = 0; k < tot; k++) begin
            logic [6:0] v = '0;
            for (int j = 0; j < 7; j++) begin
                int idx = k - j;
                if (idx >= 0 && idx < n) v[6-j] = fb[idx];
            end
            exp_cw.push_back({^(v & G0), ^(v & G1), ^(v & G2)});
            exp_last.push_back(k == tot - 1);
        end
        for (int i = 0; i < n; i++) begin
            in_bit.push_back(fb[i]);
            in_last.push_back(i == n - 1);
        end
        fb.delete();
    endtask

    // Entered and left at posedge+1. rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0.
    task automatic run(input int rdy_mode, input bit rand_vld, input string tag);
        int         cyc = 0, first = -1, lastc = -1, total = exp_cw.size();
        logic       held_v = 1'b0, held_l = 1'b0, accepted;
        logic [2:0] held_d = 3'd0;
        while (exp_cw.size() > 0 && cyc < 5000) begin
            case (rdy_mode)
                0:       do_rdy = 1'b1;
                1:       do_rdy = 1'($urandom_range(0, 1));
                default: do_rdy = (cyc % 3 == 0);
            endcase
            di_vld  = (in_bit.size() > 0) && (!rand_vld || ($urandom_range(0, 3) != 0));
            di      = (in_bit.size() > 0) ? in_bit[0] : 1'($urandom_range(0, 1));
            di_last = (in_bit.size() > 0) ? in_last[0] : 1'b0;
            @(negedge clk);
            if (held_v) begin
                check1({tag, "_hold_vld"}, do_vld, 1'b1);
                check3({tag, "_hold_do"}, do_data, held_d);
                check1({tag, "_hold_last"}, do_last, held_l);
            end
            if (do_vld) begin
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            if (do_vld && do_rdy) begin
                check3({tag, "_do"}, do_data, exp_cw[0]);
                check1({tag, "_last"}, do_last, exp_last[0]);
                void'(exp_cw.pop_front());
                void'(exp_last.pop_front());
            end
            held_v   = do_vld && !do_rdy;
            held_d   = do_data;
            held_l   = do_last;
            accepted = di_vld && di_rdy;
            @(posedge clk);
            #1;
            if (accepted) begin
                void'(in_bit.pop_front());
                void'(in_last.pop_front());
            end
            cyc++;
        end
        check_int({tag, "_remaining"}, exp_cw.size(), 0);
        if (rdy_mode == 0 && !rand_vld) check_int({tag, "_contiguous"}, lastc - first + 1, total);
        di_vld = 1'b0;
        do_rdy = 1'b1;
        @(negedge clk);
        check1({tag, "_no_extra"}, do_vld, 1'b0);
        @(posedge clk);
        #1;
        exp_cw.delete(); exp_last.delete(); in_bit.delete(); in_last.delete();
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_di_rdy", di_rdy, 1'b0);
        check1("rst_do_vld", do_vld, 1'b0);
        check3("rst_do", do_data, 3'd0);
        check1("rst_do_last", do_last, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Impulse with di_rdy tracking through the tail
        fb.push_back(1'b1);
        push_frame();
        di = 1'b1; di_vld = 1'b1; di_last = 1'b1; do_rdy = 1'b1;
        @(negedge clk);
        check1("imp_rdy0", di_rdy, 1'b1);
        @(posedge clk);
        #1 di_vld = 1'b0;
        for (int k = 0; k <= TAIL; k++) begin
            @(negedge clk);
            check1("imp_vld", do_vld, 1'b1);
            check3("imp_do", do_data, exp_cw[k]);
            check1("imp_last", do_last, exp_last[k]);
            check1("imp_di_rdy", di_rdy, k == TAIL);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check1("imp_idle", do_vld, 1'b0);
        @(posedge clk);
        #1;
        exp_cw.delete(); exp_last.delete(); in_bit.delete(); in_last.delete();

        // All-zero 16-bit frame
        for (int i = 0; i < 16; i++) fb.push_back(1'b0);
        push_frame();
        run(0, 1'b0, "zero16");

        // Impulse under do_rdy 1,0,0 backpressure
        fb.push_back(1'b1);
        push_frame();
        run(2, 1'b0, "imp_bp");

        // Back-to-back impulse frames
        fb.push_back(1'b1); push_frame();
        fb.push_back(1'b1); push_frame();
        run(0, 1'b0, "b2b");

        // Reset mid-frame after three accepted bits
        di_vld = 1'b1; di_last = 1'b0; do_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            di = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        di_vld = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("mid_rst_vld", do_vld, 1'b0);
        check3("mid_rst_do", do_data, 3'd0);
        check1("mid_rst_last", do_last, 1'b0);
        check1("mid_rst_rdy", di_rdy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        fb.push_back(1'b1);
        push_frame();
        run(0, 1'b0, "post_rst_imp");

        // Two-bit frame then single-bit frame
        fb.push_back(1'b1); fb.push_back(1'b0); push_frame();
        fb.push_back(1'b1); push_frame();
        run(0, 1'b0, "two_frames");

        // Random frames under random handshakes
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(0, 1)));
            push_frame();
        end
        run(1, 1'b1, "random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
